// File: rtl/ext_irq_arbiter_pkg.sv
// Shared constants for the external interrupt arbiter: ID width,
// the "no source" ID and the notification FSM encodings.
package ext_irq_arbiter_pkg;

    localparam int ID_W = 5;

    localparam logic [ID_W-1:0] ID_NONE = '0;

    localparam logic [1:0] IRQ_IDLE    = 2'b00;
    localparam logic [1:0] IRQ_NOTIFY  = 2'b01;
    localparam logic [1:0] IRQ_HOLDOFF = 2'b10;

endpackage

// File: rtl/ext_irq_arbiter_irq_gateway.sv
// One external interrupt source: synchroniser, edge history and the
// pending / in-service bits with their set and clear rules.
module ext_irq_arbiter_irq_gateway (
    input  logic CLK,
    input  logic RESET,
    input  logic IRQ,
    input  logic EDGE_MODE,
    input  logic CLAIM_HIT,
    input  logic COMPLETE_HIT,
    output logic PENDING,
    output logic IN_SERVICE
);

    logic sync_q1;
    logic sync_q2;   // synchronised level
    logic hist_q;    // synchronised level, one cycle older
    logic set_req;

    // Two-flop synchroniser plus edge history; history resets to 0 so a
    // line held high through reset produces exactly one edge afterwards.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync_q1 <= IRQ;
            sync_q2 <= sync_q1;
            hist_q  <= sync_q2;
        end
    end

    // Edge sources queue one event even while in service; level sources
    // only re-arm once idle and not already pending.
    assign set_req = EDGE_MODE ? (sync_q2 & ~hist_q)
                               : (sync_q2 & ~IN_SERVICE & ~PENDING);

    // Pending bit: a new event wins over a simultaneous claim.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)          PENDING <= 1'b0;
        else if (set_req)   PENDING <= 1'b1;
        else if (CLAIM_HIT) PENDING <= 1'b0;
    end

    // In-service bit: set by claim, cleared by a matching complete.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)             IN_SERVICE <= 1'b0;
        else if (CLAIM_HIT)    IN_SERVICE <= 1'b1;
        else if (COMPLETE_HIT) IN_SERVICE <= 1'b0;
    end

endmodule

// File: rtl/ext_irq_arbiter.sv
// External interrupt arbiter: per-source gateways, fixed-priority
// selection (lowest ID wins), claim/complete decode and the request FSM
// that drives E_IRQ / CLAIM_ID toward machine_control.
module ext_irq_arbiter
    import ext_irq_arbiter_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_SRC-1:0] IRQ_SRC,
    input  logic [N_SRC-1:0] EDGE_MODE,
    input  logic [N_SRC-1:0] SRC_ENABLE,
    input  logic             CLAIM,
    input  logic             COMPLETE,
    input  logic [ID_W-1:0]  COMPLETE_ID,
    output logic             E_IRQ,
    output logic [ID_W-1:0]  CLAIM_ID,
    output logic [N_SRC-1:0] PENDING,
    output logic [N_SRC-1:0] IN_SERVICE
);

    logic [1:0]       state;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] claim_hit;
    logic [N_SRC-1:0] complete_hit;
    logic [ID_W-1:0]  winner;
    logic             any_elig;
    logic             claim_fire;

    assign eligible   = PENDING & SRC_ENABLE & ~IN_SERVICE;
    assign any_elig   = |eligible;
    // The claimed ID is the one being presented in the same cycle.
    assign claim_fire = (state == IRQ_NOTIFY) && CLAIM && (CLAIM_ID != ID_NONE);

    // Priority encoder: scan high to low so the lowest ID is written last.
    always_comb begin
        winner = ID_NONE;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_W'(i + 1);
        end
    end

    // One-hot claim/complete decode; out-of-range or idle completes hit nothing.
    always_comb begin
        claim_hit    = '0;
        complete_hit = '0;
        for (int i = 0; i < N_SRC; i++) begin
            claim_hit[i]    = claim_fire && (CLAIM_ID == ID_W'(i + 1));
            complete_hit[i] = COMPLETE && (COMPLETE_ID == ID_W'(i + 1)) && IN_SERVICE[i];
        end
    end

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        ext_irq_arbiter_irq_gateway u_gw (
            .CLK          (CLK),
            .RESET        (RESET),
            .IRQ          (IRQ_SRC[g]),
            .EDGE_MODE    (EDGE_MODE[g]),
            .CLAIM_HIT    (claim_hit[g]),
            .COMPLETE_HIT (complete_hit[g]),
            .PENDING      (PENDING[g]),
            .IN_SERVICE   (IN_SERVICE[g])
        );
    end

    // Request FSM with registered outputs; HOLDOFF drops E_IRQ for one
    // cycle after a claim so the core never sees a stale request.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IRQ_IDLE;
            E_IRQ    <= 1'b0;
            CLAIM_ID <= ID_NONE;
        end else begin
            case (state)
                IRQ_IDLE, IRQ_HOLDOFF: begin
                    if (any_elig) begin
                        state    <= IRQ_NOTIFY;
                        E_IRQ    <= 1'b1;
                        CLAIM_ID <= winner;
                    end else begin
                        state    <= IRQ_IDLE;
                        E_IRQ    <= 1'b0;
                        CLAIM_ID <= ID_NONE;
                    end
                end
                IRQ_NOTIFY: begin
                    if (claim_fire) begin
                        state    <= IRQ_HOLDOFF;
                        E_IRQ    <= 1'b0;
                        CLAIM_ID <= ID_NONE;
                    end else if (any_elig) begin
                        E_IRQ    <= 1'b1;
                        CLAIM_ID <= winner;
                    end else begin
                        state    <= IRQ_IDLE;
                        E_IRQ    <= 1'b0;
                        CLAIM_ID <= ID_NONE;
                    end
                end
                default: begin
                    state    <= IRQ_IDLE;
                    E_IRQ    <= 1'b0;
                    CLAIM_ID <= ID_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_irq_arbiter.sv
// Directed bench for ext_irq_arbiter: expected output snapshots are queued
// as each step is driven and checked once the step's clock edges elapse.
module tb_ext_irq_arbiter;
    import ext_irq_arbiter_pkg::*;

    localparam int N = 8;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [N-1:0]    IRQ_SRC;
    logic [N-1:0]    EDGE_MODE;
    logic [N-1:0]    SRC_ENABLE;
    logic            CLAIM;
    logic            COMPLETE;
    logic [ID_W-1:0] COMPLETE_ID;
    logic            E_IRQ;
    logic [ID_W-1:0] CLAIM_ID;
    logic [N-1:0]    PENDING;
    logic [N-1:0]    IN_SERVICE;

    ext_irq_arbiter #(.N_SRC(N)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IRQ_SRC     (IRQ_SRC),
        .EDGE_MODE   (EDGE_MODE),
        .SRC_ENABLE  (SRC_ENABLE),
        .CLAIM       (CLAIM),
        .COMPLETE    (COMPLETE),
        .COMPLETE_ID (COMPLETE_ID),
        .E_IRQ       (E_IRQ),
        .CLAIM_ID    (CLAIM_ID),
        .PENDING     (PENDING),
        .IN_SERVICE  (IN_SERVICE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic            e_irq;
        logic [ID_W-1:0] id;
        logic [N-1:0]    pend;
        logic [N-1:0]    isv;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic cmp(input string tag, input string fld,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    // Queue the expected snapshot, advance n edges, then drain and compare.
    task automatic step(input int n, input string tag, input logic e,
                        input logic [ID_W-1:0] id, input logic [N-1:0] p,
                        input logic [N-1:0] s);
        exp_t  x;
        exp_t  y;
        string t;
        x.e_irq = e;
        x.id    = id;
        x.pend  = p;
        x.isv   = s;
        exp_q.push_back(x);
        tag_q.push_back(tag);
        tick(n);
        while (exp_q.size() > 0) begin
            y = exp_q.pop_front();
            t = tag_q.pop_front();
            cmp(t, "E_IRQ",      32'(E_IRQ),      32'(y.e_irq));
            cmp(t, "CLAIM_ID",   32'(CLAIM_ID),   32'(y.id));
            cmp(t, "PENDING",    32'(PENDING),    32'(y.pend));
            cmp(t, "IN_SERVICE", 32'(IN_SERVICE), 32'(y.isv));
        end
    endtask

    initial begin
        RESET       = 1'b1;
        IRQ_SRC     = '0;
        EDGE_MODE   = 8'h08;     // source 4 edge-triggered, others level
        SRC_ENABLE  = 8'hFF;
        CLAIM       = 1'b0;
        COMPLETE    = 1'b0;
        COMPLETE_ID = '0;
        tick(2);
        step(0, "reset", 0, 0, 0, 0);
        RESET = 1'b0;

        // Level source 3: request, claim, masked while in service, re-arm on complete
        IRQ_SRC[2] = 1'b1;
        step(2, "lvl3_sync",   0, 0, 8'h00, 8'h00);
        step(1, "lvl3_pend",   0, 0, 8'h04, 8'h00);
        step(1, "lvl3_req",    1, 3, 8'h04, 8'h00);
        CLAIM = 1'b1;
        step(1, "lvl3_claim",  0, 0, 8'h00, 8'h04);
        CLAIM = 1'b0;
        step(1, "lvl3_idle",   0, 0, 8'h00, 8'h04);
        step(3, "lvl3_masked", 0, 0, 8'h00, 8'h04);
        COMPLETE = 1'b1; COMPLETE_ID = 5'd3;
        step(1, "lvl3_cmpl",   0, 0, 8'h00, 8'h00);
        COMPLETE = 1'b0;
        step(1, "lvl3_repend", 0, 0, 8'h04, 8'h00);
        step(1, "lvl3_rereq",  1, 3, 8'h04, 8'h00);
        CLAIM = 1'b1;
        step(1, "lvl3_claim2", 0, 0, 8'h00, 8'h04);
        CLAIM = 1'b0; IRQ_SRC[2] = 1'b0;
        tick(3);
        COMPLETE = 1'b1; COMPLETE_ID = 5'd3;
        step(1, "lvl3_done",   0, 0, 8'h00, 8'h00);
        COMPLETE = 1'b0;
        step(2, "lvl3_quiet",  0, 0, 8'h00, 8'h00);

        // Priority: sources 2 and 5 together
        IRQ_SRC = 8'h12;
        step(3, "prio_pend",   0, 0, 8'h12, 8'h00);
        step(1, "prio_req",    1, 2, 8'h12, 8'h00);
        CLAIM = 1'b1;
        step(1, "prio_claim2", 0, 0, 8'h10, 8'h02);
        CLAIM = 1'b0;
        step(1, "prio_next",   1, 5, 8'h10, 8'h02);
        CLAIM = 1'b1;
        step(1, "prio_claim5", 0, 0, 8'h00, 8'h12);
        CLAIM = 1'b0;
        step(1, "prio_idle",   0, 0, 8'h00, 8'h12);
        IRQ_SRC = '0;
        tick(3);
        COMPLETE = 1'b1; COMPLETE_ID = 5'd2;
        step(1, "prio_cmpl2",  0, 0, 8'h00, 8'h10);
        COMPLETE_ID = 5'd5;
        step(1, "prio_cmpl5",  0, 0, 8'h00, 8'h00);
        COMPLETE = 1'b0;

        // Preemption in NOTIFY, then claim + complete of different IDs together
        IRQ_SRC[5] = 1'b1;
        step(4, "pre_req6",    1, 6, 8'h20, 8'h00);
        IRQ_SRC[0] = 1'b1;
        step(3, "pre_pend1",   1, 6, 8'h21, 8'h00);
        step(1, "pre_swap",    1, 1, 8'h21, 8'h00);
        CLAIM = 1'b1;
        step(1, "pre_claim1",  0, 0, 8'h20, 8'h01);
        CLAIM = 1'b0; IRQ_SRC[0] = 1'b0;
        step(1, "pre_back6",   1, 6, 8'h20, 8'h01);
        CLAIM = 1'b1; COMPLETE = 1'b1; COMPLETE_ID = 5'd1;
        step(1, "pre_clm_cpl", 0, 0, 8'h00, 8'h20);
        CLAIM = 1'b0; COMPLETE = 1'b0;
        step(1, "pre_idle",    0, 0, 8'h00, 8'h20);
        IRQ_SRC[5] = 1'b0;
        tick(3);
        COMPLETE = 1'b1; COMPLETE_ID = 5'd6;
        step(1, "pre_done",    0, 0, 8'h00, 8'h00);
        COMPLETE = 1'b0;

        // Edge source 4: one queued event for two pulses, bad completes ignored
        IRQ_SRC[3] = 1'b1; tick(2); IRQ_SRC[3] = 1'b0;
        step(1, "edge_pend",   0, 0, 8'h08, 8'h00);
        step(1, "edge_req",    1, 4, 8'h08, 8'h00);
        CLAIM = 1'b1;
        step(1, "edge_claim",  0, 0, 8'h00, 8'h08);
        CLAIM = 1'b0;
        for (int k = 0; k < 2; k++) begin
            IRQ_SRC[3] = 1'b1; tick(2); IRQ_SRC[3] = 1'b0; tick(3);
        end
        step(1, "edge_once",   0, 0, 8'h08, 8'h08);
        COMPLETE = 1'b1; COMPLETE_ID = 5'd0;
        step(1, "edge_id0",    0, 0, 8'h08, 8'h08);
        COMPLETE_ID = 5'd9;
        step(1, "edge_id9",    0, 0, 8'h08, 8'h08);
        COMPLETE_ID = 5'd4;
        step(1, "edge_cmpl",   0, 0, 8'h08, 8'h00);
        COMPLETE = 1'b0;
        step(1, "edge_rereq",  1, 4, 8'h08, 8'h00);
        CLAIM = 1'b1;
        step(1, "edge_claim2", 0, 0, 8'h00, 8'h08);
        CLAIM = 1'b0;
        step(1, "edge_idle",   0, 0, 8'h00, 8'h08);
        COMPLETE = 1'b1; COMPLETE_ID = 5'd4;
        step(1, "edge_done",   0, 0, 8'h00, 8'h00);
        COMPLETE = 1'b0;

        // Edge source 4: new edge lands on the claim cycle, set wins
        IRQ_SRC[3] = 1'b1; tick(2); IRQ_SRC[3] = 1'b0;
        step(1, "sw_pend",     0, 0, 8'h08, 8'h00);
        step(1, "sw_req",      1, 4, 8'h08, 8'h00);
        IRQ_SRC[3] = 1'b1; tick(2); IRQ_SRC[3] = 1'b0;
        CLAIM = 1'b1;
        step(1, "sw_setwins",  0, 0, 8'h08, 8'h08);
        CLAIM = 1'b0;
        step(1, "sw_hold",     0, 0, 8'h08, 8'h08);
        COMPLETE = 1'b1; COMPLETE_ID = 5'd4;
        step(1, "sw_cmpl",     0, 0, 8'h08, 8'h00);
        COMPLETE = 1'b0;
        step(1, "sw_rereq",    1, 4, 8'h08, 8'h00);
        CLAIM = 1'b1;
        step(1, "sw_claim",    0, 0, 8'h00, 8'h08);
        CLAIM = 1'b0; COMPLETE = 1'b1; COMPLETE_ID = 5'd4;
        step(1, "sw_done",     0, 0, 8'h00, 8'h00);
        COMPLETE = 1'b0;

        // Enable gating on source 7
        SRC_ENABLE[6] = 1'b0; IRQ_SRC[6] = 1'b1;
        step(5, "en_off",      0, 0, 8'h40, 8'h00);
        SRC_ENABLE[6] = 1'b1;
        step(1, "en_on",       1, 7, 8'h40, 8'h00);

        // Asynchronous reset while in NOTIFY, level line still high
        RESET = 1'b1;
        #1;
        step(0, "rst_async",   0, 0, 8'h00, 8'h00);
        tick(1);
        RESET = 1'b0;
        step(3, "rst_pend",    0, 0, 8'h40, 8'h00);
        step(1, "rst_rereq",   1, 7, 8'h40, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
